banco_reg_ir_memoria: RTL and testbench

Storage core of the multicycle MIPS datapath. It combines three sub-blocks:
- a byte-addressed unified instruction/data memory (Memoria function);
- an instruction register that latches memory output and splits it into fields (Instr_Reg function);
- the 32x32 general-purpose register file (Banco_reg function).

The control FSM drives all write enables. The datapath (PC, A/B, ALUOut, MDR) consumes the outputs.

---
 rtl/banco_reg_ir_memoria.sv | 104 ++++++++++
 tb/tb_banco_reg_ir_memoria.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/banco_reg_ir_memoria.sv
`default_nettype none
// ============================================================================
// Module      : banco_reg_ir_memoria
// Description : Multicycle MIPS storage core: unified byte-addressed memory,
//               instruction register and 32x32 general-purpose register file.
// Revision    : 1.0 - initial release
// ============================================================================
module banco_reg_ir_memoria #(
  parameter int          MEM_ADDR_BITS = 8,
  parameter logic [31:0] SP_RESET      = 32'd227
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic        Wr,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  input  logic        Load_ir,
  output logic [5:0]  Instr31_26,
  output logic [4:0]  Instr25_21,
  output logic [4:0]  Instr20_16,
  output logic [15:0] Instr15_0,
  input  logic        RegWrite,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2
);

  localparam int C_WORD_BITS = MEM_ADDR_BITS - 2;
  localparam int C_DEPTH     = 1 << C_WORD_BITS;
  localparam int C_SP_IDX    = 29;

  logic [31:0]            mem_q [C_DEPTH];
  logic [C_WORD_BITS-1:0] mem_idx;
  logic [31:0]            dataout_q;
  logic [31:0]            ir_q;
  logic [31:0]            ir_d;
  logic [31:0]            regs_q [32];
  logic                   reg_we;
  logic                   unused_addr_bits;

  // Byte-lane and upper address bits do not select anything; upper bits alias.
  assign mem_idx          = Address[MEM_ADDR_BITS-1:2];
  assign unused_addr_bits = ^{Address[31:MEM_ADDR_BITS], Address[1:0]};

  // The array has no reset so a preloaded image survives; writes are held off
  // while Reset is low so a reset edge cancels a pending store.
  always_ff @(posedge Clk) begin
    if (Reset && Wr) begin
      mem_q[mem_idx] <= Datain;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dataout_q <= '0;
    end else begin
      dataout_q <= mem_q[mem_idx];
    end
  end

  assign Dataout = dataout_q;

  always_comb begin
    ir_d = ir_q;
    if (Load_ir) begin
      ir_d = dataout_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ir_q <= '0;
    end else begin
      ir_q <= ir_d;
    end
  end

  assign Instr31_26 = ir_q[31:26];
  assign Instr25_21 = ir_q[25:21];
  assign Instr20_16 = ir_q[20:16];
  assign Instr15_0  = ir_q[15:0];

  assign reg_we = RegWrite && (WriteReg != 5'd0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == C_SP_IDX) ? SP_RESET : 32'd0;
      end
    end else if (reg_we) begin
      regs_q[WriteReg] <= WriteData;
    end
  end

  // Combinational reads with no bypass: a write shows up only after its edge.
  assign ReadData1 = (ReadReg1 == 5'd0) ? 32'd0 : regs_q[ReadReg1];
  assign ReadData2 = (ReadReg2 == 5'd0) ? 32'd0 : regs_q[ReadReg2];

endmodule
`default_nettype wire

// File: tb/tb_banco_reg_ir_memoria.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_reg_ir_memoria
// Description : Directed self-checking bench for banco_reg_ir_memoria.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_reg_ir_memoria;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Address = '0;
  logic        Wr = 1'b0;
  logic [31:0] Datain = '0;
  logic [31:0] Dataout;
  logic        Load_ir = 1'b0;
  logic [5:0]  Instr31_26;
  logic [4:0]  Instr25_21;
  logic [4:0]  Instr20_16;
  logic [15:0] Instr15_0;
  logic        RegWrite = 1'b0;
  logic [4:0]  ReadReg1 = 5'd0;
  logic [4:0]  ReadReg2 = 5'd0;
  logic [4:0]  WriteReg = 5'd0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
  string    exp_tag_q [$];
  logic [31:0] exp_val_q [$];

  banco_reg_ir_memoria #(.MEM_ADDR_BITS(8), .SP_RESET(32'd227)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .Wr(Wr), .Datain(Datain),
    .Dataout(Dataout), .Load_ir(Load_ir), .Instr31_26(Instr31_26),
    .Instr25_21(Instr25_21), .Instr20_16(Instr20_16), .Instr15_0(Instr15_0),
    .RegWrite(RegWrite), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .WriteData(WriteData), .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    n_checks++;
    if (exp_val_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      tag = exp_tag_q.pop_front();
      e   = exp_val_q.pop_front();
      assert (obs === e) begin
        n_pass++;
      end else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset asserted between edges: everything clears at once.
    #1 Reset = 1'b0;
    ReadReg1 = 5'd29;
    ReadReg2 = 5'd5;
    #1;
    expect_val("rst_dataout", 32'd0);          check(Dataout);
    expect_val("rst_ir", 32'd0);               check({Instr31_26, Instr25_21, Instr20_16, Instr15_0});
    expect_val("rst_sp", 32'd227);             check(ReadData1);
    expect_val("rst_r5", 32'd0);               check(ReadData2);
    tick();
    Reset = 1'b1;

    // Memory write then read, plus aliasing addresses.
    Address = 32'h10; Wr = 1'b1; Datain = 32'h2008000A;
    tick();
    Wr = 1'b0;
    expect_val("mem_rd_0x10", 32'h2008000A);
    tick();                                    check(Dataout);
    Address = 32'h13;
    expect_val("mem_rd_0x13", 32'h2008000A);
    tick();                                    check(Dataout);
    Address = 32'h110;
    expect_val("mem_rd_0x110", 32'h2008000A);
    tick();                                    check(Dataout);

    // Instruction register load and field split.
    Load_ir = 1'b1;
    tick();
    Load_ir = 1'b0;
    expect_val("ir_op", 32'h08);               check(32'(Instr31_26));
    expect_val("ir_rs", 32'h0);                check(32'(Instr25_21));
    expect_val("ir_rt", 32'h8);                check(32'(Instr20_16));
    expect_val("ir_imm", 32'h000A);            check(32'(Instr15_0));

    // Change Dataout; IR must hold.
    Address = 32'h20; Wr = 1'b1; Datain = 32'h11111111;
    tick();
    Wr = 1'b0;
    expect_val("mem_rd_0x20", 32'h11111111);
    tick();                                    check(Dataout);
    expect_val("ir_hold", 32'h2008000A);       check({Instr31_26, Instr25_21, Instr20_16, Instr15_0});

    // Read-during-write returns the old word first.
    Wr = 1'b1; Datain = 32'h22222222;
    expect_val("rdw_old", 32'h11111111);
    tick();                                    check(Dataout);
    Wr = 1'b0;
    expect_val("rdw_new", 32'h22222222);
    tick();                                    check(Dataout);

    // Register file write, no bypass, dual-port same index, r0 discard.
    ReadReg1 = 5'd8; ReadReg2 = 5'd8;
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
    #1;
    expect_val("rf_pre_write", 32'd0);         check(ReadData1);
    tick();
    RegWrite = 1'b0;
    expect_val("rf_post_write_p1", 32'hDEADBEEF); check(ReadData1);
    expect_val("rf_post_write_p2", 32'hDEADBEEF); check(ReadData2);
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234; ReadReg1 = 5'd0;
    tick();
    RegWrite = 1'b0;
    expect_val("rf_r0", 32'd0);                check(ReadData1);
    ReadReg2 = 5'd29;
    #1;
    expect_val("rf_sp_kept", 32'd227);         check(ReadData2);

    // Reset mid-operation with writes pending on the next edge.
    ReadReg1 = 5'd8;
    Address = 32'h10; Wr = 1'b1; Datain = 32'h00000BAD;
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h00000BAD;
    #2 Reset = 1'b0;
    #1;
    expect_val("rst2_dataout", 32'd0);         check(Dataout);
    expect_val("rst2_ir", 32'd0);              check({Instr31_26, Instr25_21, Instr20_16, Instr15_0});
    expect_val("rst2_r8", 32'd0);              check(ReadData1);
    expect_val("rst2_sp", 32'd227);            check(ReadData2);
    tick();
    Wr = 1'b0; RegWrite = 1'b0;
    #2 Reset = 1'b1;
    expect_val("rst2_mem_kept", 32'h2008000A);
    tick();                                    check(Dataout);
    expect_val("rst2_r8_no_write", 32'd0);     check(ReadData1);

    if (exp_val_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_val_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
